seg7_scan_drv: RTL
==================

Name: seg7_scan_drv

Overview:
- Multiplexed 4-digit 7-segment driver for the hh:mm display.
- Sits directly downstream of the minute and hour counters. It consumes their fully encoded 4-bit digit codes, e.g. the 0-5 tens-of-minutes code.
- Snapshots the four codes once per frame, rejecting unstable values from the ripple-clocked counters.
- Time-multiplexes the digits onto one segment bus with one-hot anode select, inter-digit blanking and a colon output.

Parameters:
- PRESC_W, 4: dwell per digit = 2**PRESC_W clk_i cycles.
- BLANK_CYC, 2: blanking cycles at the end of each dwell; legal range 1 to (2**PRESC_W)-1.
- SEG_ACTIVE_LOW, 0: 1 inverts segment_o, anode_o and colon_o polarity.
- BLINK_FRAMES, 64: frames per colon half-period; used only with COLON_BLINK_EN.

Ports:
- clk_i  in  1  scan clock, nominally 32768 Hz.
- rstn_i  in  1  reset, asynchronous, active-low.
- digit0_i  in  4  minute-units code.
- digit1_i  in  4  minute-tens code (upper bit 0 from the counter).
- digit2_i  in  4  hour-units code.
- digit3_i  in  4  hour-tens code.
- segment_o  out  7  segments {g,f,e,d,c,b,a}, registered.
- anode_o  out  4  one-hot digit select, bit n = digit n, registered.
- colon_o  out  1  colon segment, registered.
- frame_o  out  1  one-cycle pulse marking the first cycle of each frame, registered.

Behaviour:
- Clock and reset: one clock domain, clk_i. rstn_i is asynchronous and active-low.
- Reset values (all outputs at inactive level; levels below for SEG_ACTIVE_LOW=0, all inverted when 1):
  - presc=0, idx=0.
  - Sample registers s1, s2 and snapshot register snap all 0.
  - segment_o=0, anode_o=0, colon_o=0, frame_o=0.
- Prescaler: presc increments every cycle and wraps at 2**PRESC_W-1. On wrap, idx increments modulo 4.
- State is derived from presc:
  - DRIVE when presc < 2**PRESC_W-BLANK_CYC.
  - BLANK otherwise.
- Input sampling: every cycle, s1 <= {digit3..digit0} and s2 <= s1.
- Frame start (presc==0 and idx==0):
  - If s1==s2, snap <= s1.
  - Otherwise snap holds its previous value; the frame is re-shown unchanged.
  - frame_o=1 on the following cycle only.
- Output latency is one cycle from presc/idx.
  - DRIVE: anode_o = onehot(idx), segment_o = decode(snap[idx]).
  - BLANK: anode_o=0, segment_o=0.
  - Therefore anode_o never changes directly from one one-hot value to another.
- Decode table (gfedcba), SEG_ACTIVE_LOW=0:
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110
  - 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111
  - codes 10-15 = 1000000 (dash).
- Leading-zero blank: digit 3 with code 0 drives segment_o=0. Its anode still pulses, which keeps duty uniform.
- Colon: colon_o=1 from the first cycle after reset release, constant, unless COLON_BLINK_EN is defined.
- First frame after reset: idx=0 and presc=0 in cycle 0, so the snapshot loads from s1/s2.
  - s1/s2 are not yet filled with the external codes at that point.
  - Frame 0 therefore shows reset contents; real data appears from frame 1.
- Reset asserted mid-scan: all outputs go inactive immediately and asynchronously. Scan restarts at digit 0.

Optional Feature:
- Macro: COLON_BLINK_EN.
- Defined:
  - An 8-bit frame counter counts frame starts.
  - colon_o toggles when the counter reaches BLINK_FRAMES-1; the counter then clears.
  - colon_o resets to 0 and first turns on after BLINK_FRAMES frames.
- Undefined: no frame counter; colon_o=1 constant after reset.

Decomposition:
- Package seg7_pkg holds:
  - SEG_* decode constants for 0-9 and dash.
  - Digit-index width constant (2).
  - Default parameter values.
- Sub-module seg7_decode: combinational 4-bit code to 7-bit segments. It includes the dash case and does no polarity handling; polarity is applied in the top block.

Test Plan (PRESC_W=2, BLANK_CYC=1 unless stated):
- Sequencing: release reset, digits {3,2,1,0}={1,2,3,4}.
  - From frame 1: anode_o repeats 0001 x3, 0000 x1, 0010 x3, 0000, 0100 x3, 0000, 1000 x3, 0000.
  - frame_o pulses every 16 cycles.
- Decode: digit1=5 -> segment_o=1101101 while anode_o=0010. digit0=4'hA -> 1000000. digit3=0 -> 0000000 while anode_o=1000.
- Update timing: change digit0 from 7 to 8 mid-frame.
  - Display keeps 0000111 for the rest of that frame.
  - Shows 1111111 from the next frame start.
- Unstable input: toggle digit2 every cycle across a frame start -> previous snapshot retained for that frame.
- Async reset: assert rstn_i mid-dwell -> same-cycle anode_o=0, segment_o=0, colon_o=0. On release, scan restarts with digit 0.
- Colon blink: with COLON_BLINK_EN and BLINK_FRAMES=2 -> colon_o toggles on every second frame_o pulse. Without the macro, colon_o stays 1.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants for the hh:mm multiplexed 7-segment driver:
// segment patterns {g,f,e,d,c,b,a}, digit index width and defaults.
package seg7_pkg;

  localparam int unsigned IDX_W = 2;

  localparam int unsigned DEF_PRESC_W        = 4;
  localparam int unsigned DEF_BLANK_CYC      = 2;
  localparam int unsigned DEF_SEG_ACTIVE_LOW = 0;
  localparam int unsigned DEF_BLINK_FRAMES   = 64;

  localparam logic [6:0] SEG_0    = 7'b0111111;
  localparam logic [6:0] SEG_1    = 7'b0000110;
  localparam logic [6:0] SEG_2    = 7'b1011011;
  localparam logic [6:0] SEG_3    = 7'b1001111;
  localparam logic [6:0] SEG_4    = 7'b1100110;
  localparam logic [6:0] SEG_5    = 7'b1101101;
  localparam logic [6:0] SEG_6    = 7'b1111101;
  localparam logic [6:0] SEG_7    = 7'b0000111;
  localparam logic [6:0] SEG_8    = 7'b1111111;
  localparam logic [6:0] SEG_9    = 7'b1101111;
  localparam logic [6:0] SEG_DASH = 7'b1000000;

endpackage

// File: rtl/seg7_decode.sv
// Digit code to active-high segment pattern; codes 10-15 show a dash.
// Polarity is handled by the caller.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] code_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    unique case (code_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan_drv.sv
// 4-digit multiplexed 7-segment scanner with per-frame input snapshot.
// Optional COLON_BLINK_EN makes the colon blink every BLINK_FRAMES frames.
module seg7_scan_drv
  import seg7_pkg::*;
#(
  parameter int unsigned PRESC_W        = DEF_PRESC_W,
  parameter int unsigned BLANK_CYC      = DEF_BLANK_CYC,
  parameter int unsigned SEG_ACTIVE_LOW = DEF_SEG_ACTIVE_LOW,
  parameter int unsigned BLINK_FRAMES   = DEF_BLINK_FRAMES
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic [3:0] digit0_i,
  input  logic [3:0] digit1_i,
  input  logic [3:0] digit2_i,
  input  logic [3:0] digit3_i,
  output logic [6:0] segment_o,
  output logic [3:0] anode_o,
  output logic       colon_o,
  output logic       frame_o
);

  localparam int unsigned DWELL = 2 ** PRESC_W;
  localparam logic [PRESC_W-1:0] DRIVE_END =
    PRESC_W'(DWELL - BLANK_CYC);
  localparam logic POL = (SEG_ACTIVE_LOW != 0);

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [15:0]        s1_q, s2_q, snap_q, snap_d;
  logic [6:0]         seg_q, seg_d, dec_seg;
  logic [3:0]         an_q, an_d, cur_code;
  logic               colon_q, colon_d;
  logic               frame_q;
  logic               frame_start, drive, lead_zero;

  assign frame_start = (presc_q == '0) && (idx_q == '0);
  assign drive       = presc_q < DRIVE_END;
  assign presc_d     = presc_q + 1'b1;
  assign idx_d       = (presc_q == '1) ? idx_q + 1'b1 : idx_q;

  // A snapshot only loads when two consecutive samples agree.
  assign snap_d = (frame_start && (s1_q == s2_q)) ? s1_q : snap_q;

  // The new snapshot is shown from the very first cycle of its frame.
  assign cur_code  = snap_d[{idx_q, 2'b00} +: 4];
  assign lead_zero = (idx_q == 2'd3) && (cur_code == 4'd0);

  seg7_decode u_dec (
    .code_i (cur_code),
    .seg_o  (dec_seg)
  );

  always_comb begin
    seg_d = '0;
    an_d  = '0;
    if (drive) begin
      an_d = 4'(4'b0001 << idx_q);
      if (!lead_zero) seg_d = dec_seg;
    end
  end

`ifdef COLON_BLINK_EN
  logic [7:0] fcnt_q, fcnt_d;

  always_comb begin
    fcnt_d  = fcnt_q;
    colon_d = colon_q;
    if (frame_start) begin
      if (fcnt_q == 8'(BLINK_FRAMES - 1)) begin
        fcnt_d  = '0;
        colon_d = ~colon_q;
      end else begin
        fcnt_d = fcnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) fcnt_q <= '0;
    else         fcnt_q <= fcnt_d;
  end
`else
  logic unused_blink;
  assign unused_blink = ^BLINK_FRAMES;
  assign colon_d      = 1'b1;
`endif

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      presc_q <= '0;
      idx_q   <= '0;
      s1_q    <= '0;
      s2_q    <= '0;
      snap_q  <= '0;
      seg_q   <= '0;
      an_q    <= '0;
      colon_q <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      presc_q <= presc_d;
      idx_q   <= idx_d;
      s1_q    <= {digit3_i, digit2_i, digit1_i, digit0_i};
      s2_q    <= s1_q;
      snap_q  <= snap_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
      colon_q <= colon_d;
      frame_q <= frame_start;
    end
  end

  assign segment_o = seg_q ^ {7{POL}};
  assign anode_o   = an_q ^ {4{POL}};
  assign colon_o   = colon_q ^ POL;
  assign frame_o   = frame_q;

endmodule
